irq_pending_latch: RTL and testbench

- Captures up to four asynchronous interrupt/request lines and holds them as sticky pending bits until acknowledged.
- Applies a software-writable mask and presents the masked vector as the 4-bit request input of the downstream 4-to-2 priority encoder.
- Accepts acknowledges by encoded index; the index width matches the encoder's 2-bit `out`.
- Sits directly upstream of the priority encoder and converts raw, bouncing-in-time events into a stable, cycle-synchronous request vector.

---
 rtl/irq_pending_latch_if.sv | 25 ++
 rtl/irq_pending_latch.sv | 100 ++++++++++
 tb/tb_irq_pending_latch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pending_latch_if.sv
// Bundle between the request source / register block and the pending latch.
// The latch side (slave) receives raw request lines, mask writes and acks,
// and returns the pending/overflow state and the masked request vector.
interface irq_pending_latch_if;
  logic [3:0] req_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack_valid;
  logic [1:0] ack_idx;
  logic [3:0] pend_vec;
  logic [3:0] pend_raw;
  logic [3:0] mask;
  logic [3:0] ovf;
  logic       any_pend;

  modport master (
    output req_in, mask_we, mask_wdata, ack_valid, ack_idx,
    input  pend_vec, pend_raw, mask, ovf, any_pend
  );

  modport slave (
    input  req_in, mask_we, mask_wdata, ack_valid, ack_idx,
    output pend_vec, pend_raw, mask, ovf, any_pend
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Synchronizes four asynchronous request lines, latches events as sticky
// pending bits until acknowledged by index, tracks per-line overflow and
// presents a masked request vector for the downstream priority encoder.
module irq_pending_latch #(
  parameter int unsigned SYNC_STAGES = 2,  // 2..3
  parameter int unsigned EDGE_MODE   = 1   // 1: rising edge sets, 0: level sets
) (
  input logic               clk,
  input logic               rst_n,
  irq_pending_latch_if.slave bus
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync;
  logic [3:0] sync_d_q;
  logic [3:0] evt_d, evt_q;
  logic [3:0] ack_hit;
  logic [3:0] pend_d, pend_q;
  logic [3:0] ovf_d, ovf_q;
  logic [3:0] mask_d, mask_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      sync_d_q <= '0;
    end else begin
      sync_q[0] <= bus.req_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_d_q <= sync;
    end
  end

  // Event detection and one-hot decode of the acknowledged index.
  always_comb begin
    evt_d   = '0;
    ack_hit = '0;
    if (EDGE_MODE != 0) begin
      evt_d = sync & ~sync_d_q;
    end else begin
      evt_d = sync;
    end
    if (bus.ack_valid) begin
      ack_hit = 4'b0001 << bus.ack_idx;
    end
  end

  // Next-state for pending, overflow and mask; a new event beats a same-cycle ack.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    mask_d = mask_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (evt_q[i]) begin
        pend_d[i] = 1'b1;
      end else if (ack_hit[i]) begin
        pend_d[i] = 1'b0;
      end
      if (EDGE_MODE == 0) begin
        ovf_d[i] = 1'b0;
      end else if (evt_q[i] && pend_q[i] && !ack_hit[i]) begin
        ovf_d[i] = 1'b1;
      end else if (ack_hit[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
    if (bus.mask_we) begin
      mask_d = bus.mask_wdata;
    end
  end

  // State registers; the event is registered so capture lands
  // SYNC_STAGES+1 edges after the line is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      mask_q <= '0;
    end else begin
      evt_q  <= evt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
    end
  end

  assign bus.pend_raw = pend_q;
  assign bus.mask     = mask_q;
  assign bus.ovf      = ovf_q;
  assign bus.pend_vec = pend_q & ~mask_q;
  assign bus.any_pend = |(pend_q & ~mask_q);

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: table of directed cycles, hand sequences for
// overflow / set-beats-clear / async reset, then random stimulus. Two DUTs
// (edge mode, 2 stages; level mode, 3 stages) are checked every cycle
// against a delay-line reference model.
module tb_irq_pending_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack_valid;
  logic [1:0] ack_idx;

  irq_pending_latch_if bif_e ();
  irq_pending_latch_if bif_l ();

  assign bif_e.req_in     = req_in;
  assign bif_e.mask_we    = mask_we;
  assign bif_e.mask_wdata = mask_wdata;
  assign bif_e.ack_valid  = ack_valid;
  assign bif_e.ack_idx    = ack_idx;
  assign bif_l.req_in     = req_in;
  assign bif_l.mask_we    = mask_we;
  assign bif_l.mask_wdata = mask_wdata;
  assign bif_l.ack_valid  = ack_valid;
  assign bif_l.ack_idx    = ack_idx;

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif_e.slave));
  irq_pending_latch #(.SYNC_STAGES(3), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .bus(bif_l.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: hist[j] is req_in as sampled j edges ago.
  // A line's event at an edge is seen SYNC_STAGES+1 edges after its sample.
  logic [3:0]  hist [8];
  logic [3:0]  m_pend [2];
  logic [3:0]  m_ovf  [2];
  logic [3:0]  m_mask;
  int unsigned cfg_s    [2] = '{2, 3};
  bit          cfg_edge [2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 8; j++) hist[j] = '0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0;
      m_ovf[d]  = '0;
    end
    m_mask = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = req_in;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          logic now_b, prev_b, e, hit;
          now_b  = hist[1 + cfg_s[d]][i];
          prev_b = hist[2 + cfg_s[d]][i];
          e   = cfg_edge[d] ? (now_b && !prev_b) : now_b;
          hit = ack_valid && (int'(ack_idx) == i);
          if (e) begin
            if (cfg_edge[d] && m_pend[d][i] && !hit) m_ovf[d][i] = 1'b1;
            else if (hit) m_ovf[d][i] = 1'b0;
            m_pend[d][i] = 1'b1;
          end else if (hit) begin
            m_pend[d][i] = 1'b0;
            m_ovf[d][i]  = 1'b0;
          end
        end
      end
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  function automatic logic [16:0] exp_of(input int d);
    logic [3:0] v;
    v = m_pend[d] & ~m_mask;
    return {m_pend[d], v, m_ovf[d], m_mask, |v};
  endfunction

  task automatic check_model();
    chk("model_edge_dut", {bif_e.pend_raw, bif_e.pend_vec, bif_e.ovf, bif_e.mask, bif_e.any_pend}, exp_of(0));
    chk("model_lvl_dut",  {bif_l.pend_raw, bif_l.pend_vec, bif_l.ovf, bif_l.mask, bif_l.any_pend}, exp_of(1));
  endtask

  task automatic cyc(input logic [3:0] r, input logic we, input logic [3:0] wd,
                     input logic av, input logic [1:0] ai);
    req_in = r; mask_we = we; mask_wdata = wd; ack_valid = av; ack_idx = ai;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
  endtask

  typedef struct {
    logic [3:0] req; logic we; logic [3:0] wd; logic av; logic [1:0] ai;
    logic [3:0] e_raw; logic [3:0] e_vec; logic [3:0] e_ovf; logic [3:0] e_mask; logic e_any;
  } vec_t;
  vec_t tbl [21];

  initial begin
    // Each row: inputs sampled at one edge, edge-mode outputs expected after it.
    tbl[0]  = '{4'b0001, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b0001, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[2]  = '{4'b0001, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[3]  = '{4'b0001, 0, 4'h0, 0, 2'd0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1};
    tbl[4]  = '{4'b0000, 0, 4'h0, 1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[5]  = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[6]  = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[7]  = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[8]  = '{4'b0011, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[9]  = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[10] = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[11] = '{4'b0000, 0, 4'h0, 0, 2'd0, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1};
    tbl[12] = '{4'b0000, 0, 4'h0, 1, 2'd1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1};
    tbl[13] = '{4'b0000, 0, 4'h0, 1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[14] = '{4'b0000, 1, 4'h8, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0};
    tbl[15] = '{4'b1000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0};
    tbl[16] = '{4'b1000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0};
    tbl[17] = '{4'b1000, 0, 4'h0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0};
    tbl[18] = '{4'b1000, 0, 4'h0, 0, 2'd0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0};
    tbl[19] = '{4'b1000, 1, 4'h0, 0, 2'd0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1};
    tbl[20] = '{4'b0000, 0, 4'h0, 1, 2'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};

    rst_n = 1'b0;
    req_in = '0; mask_we = 1'b0; mask_wdata = '0; ack_valid = 1'b0; ack_idx = '0;
    model_reset();
    idle(3);
    chk("reset_state", 17'({bif_e.pend_raw, bif_e.pend_vec, bif_e.ovf, bif_e.mask, bif_e.any_pend}), 17'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 21; n++) begin
      cyc(tbl[n].req, tbl[n].we, tbl[n].wd, tbl[n].av, tbl[n].ai);
      chk($sformatf("table_row%0d", n),
          {bif_e.pend_raw, bif_e.pend_vec, bif_e.ovf, bif_e.mask, bif_e.any_pend},
          {tbl[n].e_raw, tbl[n].e_vec, tbl[n].e_ovf, tbl[n].e_mask, tbl[n].e_any});
    end

    // Overflow: two rising edges on line 2 without an ack in between.
    cyc(4'b0100, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 0, 4'h0, 0, 2'd0);
    cyc(4'b0100, 0, 4'h0, 0, 2'd0);
    idle(4);
    chk("ovf_raw", 17'(bif_e.pend_raw), 17'(4'b0100));
    chk("ovf_set", 17'(bif_e.ovf), 17'(4'b0100));
    cyc(4'b0000, 0, 4'h0, 1, 2'd2);
    chk("ovf_ack_raw", 17'(bif_e.pend_raw), 17'(4'b0000));
    chk("ovf_ack_clr", 17'(bif_e.ovf), 17'(4'b0000));

    // Set beats clear: ack idx 3 at the edge where line 3's second event lands.
    cyc(4'b1000, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 0, 4'h0, 0, 2'd0);
    cyc(4'b1000, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 0, 4'h0, 0, 2'd0);
    chk("sbc_first_set", 17'({bif_e.pend_raw, bif_e.ovf}), 17'({4'b1000, 4'b0000}));
    cyc(4'b0000, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 0, 4'h0, 1, 2'd3);
    chk("sbc_rearm", 17'({bif_e.pend_raw, bif_e.ovf}), 17'({4'b1000, 4'b0000}));
    idle(2);
    cyc(4'b0000, 0, 4'h0, 1, 2'd3);
    chk("sbc_final_clr", 17'(bif_e.pend_raw), 17'(4'b0000));

    // Reset mid-operation with pend_raw=1111, mask=0101, ovf=0010.
    cyc(4'b1111, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 0, 4'h0, 0, 2'd0);
    cyc(4'b0010, 0, 4'h0, 0, 2'd0);
    cyc(4'b0000, 1, 4'h5, 0, 2'd0);
    idle(3);
    chk("pre_reset_state", 17'({bif_e.pend_raw, bif_e.mask, bif_e.ovf}),
        17'({4'b1111, 4'b0101, 4'b0010}));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {bif_e.pend_raw, bif_e.pend_vec, bif_e.ovf, bif_e.mask, bif_e.any_pend}, 17'd0);
    check_model();
    req_in = 4'b1111;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(4'b1111, 0, 4'h0, 0, 2'd0);
    chk("held_across_release", 17'({bif_e.pend_raw, bif_e.ovf}), 17'({4'b1111, 4'b0000}));
    for (int k = 0; k < 6; k++) cyc(4'b1111, 0, 4'h0, 1, 2'(k));
    chk("held_no_reset_after_ack", 17'(bif_e.pend_raw), 17'(4'b0000));

    // Random stimulus against the reference model, with one async reset.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = req_in ^ (4'($urandom) & 4'($urandom));
      cyc(r, ($urandom_range(0, 7) == 0), 4'($urandom), 1'($urandom), 2'($urandom));
      if (n == 200) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
